// File: rtl/fullchip_inst_seq_if.sv
// ----------------------------------------------------------------------------
// fullchip_inst_seq_if
// Bundle between a host and the fullchip instruction sequencer.
//
// Handshake: a data word on in_data_0/in_data_1 is transferred on a rising
// clock edge where in_valid and in_ready are both high. in_ready is a
// registered output of the sequencer. It never depends combinationally on
// in_valid. The host may raise in_valid at any time. While in_ready is low,
// the host holds its word, and any word offered then is simply not taken.
//
// Signals:
//   start      host -> seq   one-cycle request to run a full sequence
//   in_valid   host -> seq   data word valid
//   in_ready   seq  -> host  sequencer takes a word this cycle
//   in_data_0  host -> seq   Q vector, or core0 K vector (pr*bw bits)
//   in_data_1  host -> seq   Q vector copy, or core1 K vector (pr*bw bits)
//   mem_in_0   seq  -> chip  registered core0 data
//   mem_in_1   seq  -> chip  registered core1 data
//   inst       seq  -> chip  registered 17-bit instruction word
//   busy       seq  -> host  sequence in progress
//   done       seq  -> host  one-cycle completion pulse
// ----------------------------------------------------------------------------
interface fullchip_inst_seq_if #(
  parameter int bw = 8,
  parameter int pr = 16
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [pr*bw-1:0]  in_data_0;
  logic [pr*bw-1:0]  in_data_1;
  logic [pr*bw-1:0]  mem_in_0;
  logic [pr*bw-1:0]  mem_in_1;
  logic [16:0]       inst;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data_0, in_data_1,
    input  in_ready, mem_in_0, mem_in_1, inst, busy, done
  );

  modport slave (
    input  start, in_valid, in_data_0, in_data_1,
    output in_ready, mem_in_0, mem_in_1, inst, busy, done
  );
endinterface

// File: rtl/fullchip_inst_seq.sv
// ----------------------------------------------------------------------------
// fullchip_inst_seq
// Autonomous instruction sequencer for the fullchip top. A single start pulse
// runs the whole flow, with all outputs registered:
//   Q write -> K write -> K load -> execute -> ofifo-to-pmem move.
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   reset    asynchronous, active-low reset
//   bus      fullchip_inst_seq_if.slave (host handshake, data and inst buses)
//   state_o  current FSM state, for debug
//
// inst bit map:
//   [16] ofifo_rd   [15:12] qkmem_add   [11:8] pmem_add   [7] execute
//   [6] load        [5] qmem_rd         [4] qmem_wr       [3] kmem_rd
//   [2] kmem_wr     [1] pmem_rd (always 0)                [0] pmem_wr
//
// Every register's next value is decoded from the next state and count.
// As a result, the outputs seen in a cycle always describe state_q and cnt_q
// of that same cycle.
// ----------------------------------------------------------------------------
module fullchip_inst_seq #(
  parameter int bw          = 8,
  parameter int pr          = 16,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_cycles  = 10
) (
  input  logic               clk,
  input  logic               reset,
  fullchip_inst_seq_if.slave bus,
  output logic [3:0]         state_o
);
  localparam int DW = pr * bw;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_QWR    = 4'd1;
  localparam logic [3:0] S_KWR    = 4'd2;
  localparam logic [3:0] S_GAP_A  = 4'd3;
  localparam logic [3:0] S_LOAD   = 4'd4;
  localparam logic [3:0] S_LDRAIN = 4'd5;
  localparam logic [3:0] S_GAP_B  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_GAP_C  = 4'd8;
  localparam logic [3:0] S_MOVE   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  localparam logic [7:0] TC  = 8'(total_cycle);
  localparam logic [7:0] COL = 8'(col);
  localparam logic [7:0] GAP = 8'(gap_cycles);

  logic [3:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [16:0]   inst_q, inst_d;
  logic [DW-1:0] mem0_q, mem0_d;
  logic [DW-1:0] mem1_q, mem1_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          hs_write;
  logic          hs_hold;
  logic [7:0]    lim;

  // Instruction word for the non-handshake phases, as a function of the
  // state and the cycle index within that state.
  function automatic logic [16:0] phase_inst(input logic [3:0] st,
                                             input logic [7:0] n);
    logic [16:0] w;
    w = '0;
    case (st)
      S_LOAD: begin
        // kmem read data lags the address by one cycle.
        // The address therefore starts one cycle behind kmem_rd.
        w[6]     = 1'b1;
        w[3]     = (n != 8'd0);
        w[15:12] = (n <= 8'd1) ? 4'd0 : 4'(n - 8'd1);
      end
      S_LDRAIN: w[6] = (n == 8'd0);
      S_EXEC: begin
        w[7]     = 1'b1;
        w[5]     = 1'b1;
        w[15:12] = n[3:0];
      end
      S_MOVE: begin
        // n == TC is the trailing all-zero cycle before DONE.
        if (n < TC) begin
          w[16]   = 1'b1;
          w[0]    = 1'b1;
          w[11:8] = n[3:0];
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    hs_write = 1'b0;
    hs_hold  = 1'b0;
    accept   = bus.in_valid & in_ready_q;
    lim      = (state_q == S_KWR) ? COL : TC;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_QWR;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_QWR, S_KWR: begin
        // cnt < lim : taking words
        // cnt == lim: last write is on the bus
        // cnt == lim+1: trailing zero cycle
        if (cnt_q < lim) begin
          if (accept) begin
            hs_write = 1'b1;
            cnt_d    = cnt_q + 8'd1;
            mem0_d   = bus.in_data_0;
            mem1_d   = bus.in_data_1;
          end else begin
            hs_hold = 1'b1;
          end
        end else if (cnt_q == lim) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          state_d = (state_q == S_QWR) ? S_KWR : S_GAP_A;
          cnt_d   = 8'd0;
        end
      end
      S_GAP_A: begin
        if (cnt_q == 8'd1) begin
          state_d = S_LOAD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOAD: begin
        if (cnt_q == COL) begin
          state_d = S_LDRAIN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LDRAIN: begin
        if (cnt_q == 8'd1) begin
          state_d = S_GAP_B;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP_B: begin
        if (cnt_q == GAP - 8'd1) begin
          state_d = S_EXEC;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == TC - 8'd1) begin
          state_d = S_GAP_C;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP_C: begin
        if (cnt_q == GAP - 8'd1) begin
          state_d = S_MOVE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_MOVE: begin
        if (cnt_q == TC) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    in_ready_d = ((state_d == S_QWR) && (cnt_d < TC)) ||
                 ((state_d == S_KWR) && (cnt_d < COL));
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);

    inst_d = phase_inst(state_d, cnt_d);
    if (hs_write) begin
      inst_d          = '0;
      inst_d[15:12]   = cnt_q[3:0];
      if (state_q == S_QWR) begin
        inst_d[4] = 1'b1;
      end else begin
        inst_d[2] = 1'b1;
      end
    end else if (hs_hold) begin
      // An idle handshake cycle drops the write strobe.
      // The address still holds its last value.
      inst_d    = inst_q;
      inst_d[4] = 1'b0;
      inst_d[2] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      inst_q     <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The address fields are 4 bits wide.
  // The gap counter is 8 bits wide.
  always_ff @(posedge clk) begin
    assert (total_cycle >= 1 && total_cycle <= 16 && col >= 1 && col <= 16 &&
            gap_cycles >= 1 && gap_cycles <= 255)
      else $error("fullchip_inst_seq: illegal parameter set");
  end

  assign bus.inst     = inst_q;
  assign bus.mem_in_0 = mem0_q;
  assign bus.mem_in_1 = mem1_q;
  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fullchip_inst_seq.sv
module tb_fullchip_inst_seq;
  localparam int BW  = 8;
  localparam int PR  = 16;
  localparam int COL = 8;
  localparam int TC  = 8;
  localparam int GAP = 10;
  localparam int DW  = BW * PR;

  localparam logic [16:0] F_OFIFO = 17'h10000;
  localparam logic [16:0] F_EX    = 17'h00080;
  localparam logic [16:0] F_LD    = 17'h00040;
  localparam logic [16:0] F_QRD   = 17'h00020;
  localparam logic [16:0] F_QWR   = 17'h00010;
  localparam logic [16:0] F_KRD   = 17'h00008;
  localparam logic [16:0] F_KWR   = 17'h00004;
  localparam logic [16:0] F_PWR   = 17'h00001;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state_dbg;
  int         tests_run    = 0;
  int         tests_failed = 0;

  fullchip_inst_seq_if #(.bw(BW), .pr(PR)) bus();

  fullchip_inst_seq #(
    .bw(BW), .pr(PR), .col(COL), .total_cycle(TC), .gap_cycles(GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {PR{b}};
  endfunction

  function automatic logic [16:0] iw(input logic [3:0] qk, input logic [3:0] pa,
                                     input logic [16:0] flags);
    return flags | {1'b0, qk, pa, 8'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [19:0] got;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {inst,rdy,busy,done}=%h expected 0", got);
    end
    tests_run++;
    if ({bus.mem_in_0, bus.mem_in_1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem: mem_in_0=%h mem_in_1=%h expected 0", bus.mem_in_0, bus.mem_in_1);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== 20'd0) begin
      tests_failed++;
      $display("FAIL idle_hold: {inst,rdy,busy,done}=%h expected 0", got);
    end
  endtask

  task automatic test_qwr(input bit do_start);
    logic [19:0] got, exp;
    if (do_start) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== {17'd0, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL qwr_entry: {inst,rdy,busy,done}=%h expected %h", got, {17'd0, 3'b110});
    end
    for (int n = 0; n < TC; n++) begin
      bus.in_valid  = 1'b1;
      bus.in_data_0 = rep(8'(n + 1));
      bus.in_data_1 = rep(8'(n + 1));
      step();
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      exp = {iw(4'(n), 4'd0, F_QWR), (n < TC - 1), 1'b1, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL qwr_word n=%0d: {inst,rdy,busy,done}=%h expected %h", n, got, exp);
      end
      tests_run++;
      if ({bus.mem_in_0, bus.mem_in_1} !== {rep(8'(n + 1)), rep(8'(n + 1))}) begin
        tests_failed++;
        $display("FAIL qwr_data n=%0d: mem_in_0=%h mem_in_1=%h", n, bus.mem_in_0, bus.mem_in_1);
      end
    end
    // in_valid stays high with junk data; none of it may be taken.
    bus.in_data_0 = rep(8'hEE);
    bus.in_data_1 = rep(8'hEE);
    step();
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== {17'd0, 3'b010}) begin
      tests_failed++;
      $display("FAIL qwr_tail: {inst,rdy,busy,done}=%h expected %h", got, {17'd0, 3'b010});
    end
    tests_run++;
    if (bus.mem_in_0 !== rep(8'(TC))) begin
      tests_failed++;
      $display("FAIL qwr_tail_data: mem_in_0=%h expected %h", bus.mem_in_0, rep(8'(TC)));
    end
    step();
    bus.in_valid = 1'b0;
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== {17'd0, 3'b110} || bus.mem_in_0 !== rep(8'(TC))) begin
      tests_failed++;
      $display("FAIL kwr_entry: {inst,rdy,busy,done}=%h expected %h mem_in_0=%h",
               got, {17'd0, 3'b110}, bus.mem_in_0);
    end
  endtask

  task automatic test_kwr(input bit toggle, input bit poke_start);
    logic [19:0]   got, exp;
    logic [16:0]   exp_inst;
    logic [DW-1:0] exp_m0, exp_m1;
    logic [3:0]    last_add;
    int            sent, k;
    bit            v;
    sent = 0; k = 0; last_add = 4'd0;
    exp_m0 = rep(8'(TC));
    exp_m1 = rep(8'(TC));
    while (sent < COL && k < 64) begin
      v = toggle ? (k % 2 == 0) : 1'b1;
      bus.in_valid  = v;
      bus.in_data_0 = rep(8'(8'h40 + sent));
      bus.in_data_1 = rep(8'(8'h80 + sent));
      bus.start     = poke_start && (k == 3);
      step();
      k++;
      if (v) begin
        exp_inst = iw(4'(sent), 4'd0, F_KWR);
        exp_m0   = rep(8'(8'h40 + sent));
        exp_m1   = rep(8'(8'h80 + sent));
        last_add = 4'(sent);
        sent++;
      end else begin
        exp_inst = iw(last_add, 4'd0, 17'd0);
      end
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      exp = {exp_inst, (sent < COL), 1'b1, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL kwr_cycle k=%0d: {inst,rdy,busy,done}=%h expected %h", k, got, exp);
      end
      tests_run++;
      if (bus.mem_in_0 !== exp_m0 || bus.mem_in_1 !== exp_m1) begin
        tests_failed++;
        $display("FAIL kwr_data k=%0d: mem_in_0=%h mem_in_1=%h expected %h %h",
                 k, bus.mem_in_0, bus.mem_in_1, exp_m0, exp_m1);
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load();
    logic [19:0] got, exp;
    logic [3:0]  add;
    // Data offered now must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_data_0 = rep(8'h5A);
    bus.in_data_1 = rep(8'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      tests_run++;
      if (got !== {17'd0, 3'b010}) begin
        tests_failed++;
        $display("FAIL load_gap i=%0d: {inst,rdy,busy,done}=%h expected %h", i, got, {17'd0, 3'b010});
      end
    end
    for (int i = 0; i <= COL + 1; i++) begin
      step();
      add = (i <= 1 || i == COL + 1) ? 4'd0 : 4'(i - 1);
      exp = {iw(add, 4'd0, F_LD | ((i >= 1 && i <= COL) ? F_KRD : 17'd0)), 3'b010};
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL load_cycle i=%0d: {inst,rdy,busy,done}=%h expected %h", i, got, exp);
      end
    end
    step();
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== {17'd0, 3'b010}) begin
      tests_failed++;
      $display("FAIL load_off: {inst,rdy,busy,done}=%h expected %h", got, {17'd0, 3'b010});
    end
    tests_run++;
    if (bus.mem_in_0 !== rep(8'h47) || bus.mem_in_1 !== rep(8'h87)) begin
      tests_failed++;
      $display("FAIL load_nocapture: mem_in_0=%h mem_in_1=%h", bus.mem_in_0, bus.mem_in_1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_exec(input int n_exec);
    logic [19:0] got, exp;
    for (int i = 0; i < GAP; i++) begin
      step();
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      tests_run++;
      if (got !== {17'd0, 3'b010}) begin
        tests_failed++;
        $display("FAIL gap_b i=%0d: {inst,rdy,busy,done}=%h expected %h", i, got, {17'd0, 3'b010});
      end
    end
    for (int n = 0; n < n_exec; n++) begin
      step();
      exp = {iw(4'(n), 4'd0, F_EX | F_QRD), 3'b010};
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL exec n=%0d: {inst,rdy,busy,done}=%h expected %h", n, got, exp);
      end
    end
  endtask

  task automatic test_move(input bit restart);
    logic [19:0] got, exp;
    for (int i = 0; i < GAP; i++) begin
      step();
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      tests_run++;
      if (got !== {17'd0, 3'b010}) begin
        tests_failed++;
        $display("FAIL gap_c i=%0d: {inst,rdy,busy,done}=%h expected %h", i, got, {17'd0, 3'b010});
      end
    end
    for (int n = 0; n < TC; n++) begin
      step();
      exp = {iw(4'd0, 4'(n), F_OFIFO | F_PWR), 3'b010};
      got = {bus.inst, bus.in_ready, bus.busy, bus.done};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL move n=%0d: {inst,rdy,busy,done}=%h expected %h", n, got, exp);
      end
    end
    step();
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== {17'd0, 3'b010}) begin
      tests_failed++;
      $display("FAIL move_tail: {inst,rdy,busy,done}=%h expected %h", got, {17'd0, 3'b010});
    end
    step();
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== {17'd0, 3'b001}) begin
      tests_failed++;
      $display("FAIL done_pulse: {inst,rdy,busy,done}=%h expected %h", got, {17'd0, 3'b001});
    end
    bus.start = restart;
    step();
    bus.start = 1'b0;
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    exp = restart ? {17'd0, 3'b110} : 20'd0;
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL after_done restart=%0d: {inst,rdy,busy,done}=%h expected %h", restart, got, exp);
    end
  endtask

  // Entered in the first QWR cycle of a back-to-back sequence.
  task automatic test_reset_mid();
    logic [19:0] got;
    test_qwr(1'b0);
    test_kwr(1'b0, 1'b0);
    test_load();
    test_exec(4);
    reset = 1'b0;
    #1;
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== 20'd0 || bus.mem_in_0 !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: {inst,rdy,busy,done}=%h mem_in_0=%h expected 0", got, bus.mem_in_0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: {inst,rdy,busy,done}=%h expected 0", got);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    got = {bus.inst, bus.in_ready, bus.busy, bus.done};
    tests_run++;
    if (got !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_release: {inst,rdy,busy,done}=%h expected 0", got);
    end
    test_qwr(1'b1);
    test_kwr(1'b1, 1'b0);
    test_load();
    test_exec(TC);
    test_move(1'b0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data_0 = '0;
    bus.in_data_1 = '0;
    test_reset();
    test_qwr(1'b1);
    test_kwr(1'b1, 1'b1);
    test_load();
    test_exec(TC);
    test_move(1'b1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fullchip_inst_seq.md
Name: fullchip_inst_seq

Overview:
- Hardware instruction sequencer that drives the fullchip 17-bit `inst` bus and the `mem_in_0`/`mem_in_1` data buses.
- Replaces host/bench stepping with an autonomous flow:
  - Q write
  - K write (core0/core1)
  - K load
  - execute
  - ofifo→pmem move
- Sits between a host streaming interface (valid/ready) and the fullchip top.

Parameters:
- bw, 8, Q/K element bit precision
- pr, 16, elements per vector
- col, 8, dot-product units per core (K vectors per core)
- total_cycle, 8, number of Q vectors (≤16)
- gap_cycles, 10, idle cycles between load, execute and move phases (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run the full sequence; ignored while busy
- in_valid  in  1  host data word valid (Q or K phase)
- in_ready  out  1  sequencer accepts a data word this cycle
- in_data_0  in  pr*bw  Q vector, or core0 K vector
- in_data_1  in  pr*bw  Q vector copy, or core1 K vector
- mem_in_0  out  pr*bw  registered data to fullchip core0
- mem_in_1  out  pr*bw  registered data to fullchip core1
- inst  out  17  registered instruction word to fullchip
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- inst bit map:
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] load
  - [5] qmem_rd
  - [4] qmem_wr
  - [3] kmem_rd
  - [2] kmem_wr
  - [1] pmem_rd
  - [0] pmem_wr
- pmem_rd is always 0.
- All outputs are registered.
- Reset (asserted low, any time, including mid-sequence):
  - state=IDLE
  - inst=0, mem_in_0/1=0
  - in_ready=0, busy=0, done=0
  - all counters=0
- States: IDLE → QWR → KWR → GAP_A → LOAD → LDRAIN → GAP_B → EXEC → GAP_C → MOVE → DONE → IDLE.
- IDLE:
  - inst=0
  - start=1 → QWR, cnt=0.
- QWR:
  - in_ready=1.
  - On in_valid&in_ready, the next cycle drives qmem_wr=1, qkmem_add=cnt, mem_in_0/1=in_data_0/1, then cnt++.
  - Cycle without in_valid: qmem_wr=0, address and data hold.
  - After total_cycle accepted words: one cycle with inst=0 (qkmem_add=0), then KWR, cnt=0.
- KWR:
  - Same handshake with kmem_wr; mem_in_0 = core0 K[cnt], mem_in_1 = core1 K[cnt].
  - After col words: one cycle with inst=0, then GAP_A.
- GAP_A: 2 cycles, inst=0.
- LOAD: col+1 cycles, index n=0..col.
  - load=1 throughout.
  - kmem_rd=1 for n≥1.
  - qkmem_add=0 for n≤1, n-1 for n≥2 (max col-1).
- LDRAIN:
  - Cycle 1: load=1, kmem_rd=0, qkmem_add=0.
  - Cycle 2: load=0.
- GAP_B/GAP_C: gap_cycles cycles, inst=0.
- EXEC:
  - total_cycle cycles, execute=1, qmem_rd=1, qkmem_add=0..total_cycle-1.
  - Followed by one all-zero cycle (counted in GAP_C).
- MOVE:
  - total_cycle cycles, ofifo_rd=1, pmem_wr=1, pmem_add=0..total_cycle-1.
  - Followed by one cycle inst=0.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
- in_ready=0 in every state except QWR/KWR.
  - in_valid outside QWR/KWR is ignored; no data is captured.
- Address counters are 4-bit.
  - Parameters giving total_cycle>16 or col>16 are illegal; flag with a simulation-time check.
- start during busy: ignored, no restart.
- start in the same cycle as done: accepted, next sequence begins.

Test Plan:
- Reset low mid-EXEC (execute=1, qkmem_add=3) → next sample: inst=0, busy=0, in_ready=0; after release, start runs a full clean sequence.
- start, then 8 Q words with in_valid continuous, Q[n] all elements = n+1 → qmem_wr high 8 consecutive cycles, qkmem_add 0..7, mem_in_0 = mem_in_1 = replicated byte n+1.
- During KWR, in_valid toggles 1,0,1,… → kmem_wr asserted only on accepted words; qkmem_add steps 0..7 without skips; 8 writes total; mem_in_1 carries core1 data.
- LOAD phase with col=8 → load=1 for 10 cycles; kmem_rd=1 on cycles 1..8; qkmem_add sequence 0,0,1,2,…,7,0; then load=0.
- EXEC/MOVE with total_cycle=8, gap_cycles=10 → execute&qmem_rd high 8 cycles, add 0..7; exactly 10 zero cycles; then ofifo_rd&pmem_wr high 8 cycles, pmem_add 0..7; then done pulse of width 1.
- start pulsed during KWR and again coincident with done → first ignored (sequence unchanged); second begins a new QWR on the next cycle.
